// File: rtl/cache_controller_if.sv
// Bundles the CPU, cache-array and memory-bus signals of cache_controller.
// Modport master is the controller's own view.
// Modport slave is the view of the surrounding CPU, arrays and memory.
interface cache_controller_if #(
   parameter int unsigned ADDR_W = 29,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned TAG_W = ADDR_W - IDX_W;

   // CPU load/store port
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_hit;

   // Tag/data/valid array port
   logic [IDX_W-1:0]  arr_index;
   logic              arr_we;
   logic [TAG_W-1:0]  tag_wr;
   logic [DATA_W-1:0] data_wr;
   logic              valid_wr;
   logic [TAG_W-1:0]  tag_rd;
   logic [DATA_W-1:0] data_rd;
   logic              valid_rd;

   // Memory bus
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata, cpu_hit,
      output arr_index, arr_we, tag_wr, data_wr, valid_wr,
      input  tag_rd, data_rd, valid_rd,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata, cpu_hit,
      input  arr_index, arr_we, tag_wr, data_wr, valid_wr,
      output tag_rd, data_rd, valid_rd,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped cache controller for one CPU port.
// It looks up the tag/data/valid arrays and refills a line on a read miss.
// Every store is written through to memory; a store miss does not allocate a line.
// Optional macro CACHE_CTRL_STATS_EN adds the saturating hit_cnt/miss_cnt outputs.
// All outputs are registered. The arrays read combinationally from arr_index,
// so their read data is sampled one rising edge after the index is latched.
module cache_controller #(
   parameter int unsigned ADDR_W = 29,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned DATA_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   cache_controller_if.master  bus
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0]         hit_cnt,
   output logic [15:0]         miss_cnt
`endif
);
   localparam int unsigned TAG_W = ADDR_W - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_REFILL = 2'd2,
      S_WTHRU  = 2'd3
   } state_t;

   state_t            r_state;

   // Latched request
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_we;
   logic [DATA_W-1:0] r_req_wdata;
   logic              r_hit;

   // Registered outputs
   logic              r_cpu_ready;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_cpu_hit;
   logic [IDX_W-1:0]  r_arr_index;
   logic              r_arr_we;
   logic [TAG_W-1:0]  r_tag_wr;
   logic [DATA_W-1:0] r_data_wr;
   logic              r_valid_wr;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [TAG_W-1:0]  w_req_tag;
   logic              w_hit;

   // Tag compare against the line selected by the latched index
   assign w_req_tag = r_req_addr[ADDR_W-1:IDX_W];
   assign w_hit     = bus.valid_rd & (bus.tag_rd == w_req_tag);

   // Controller FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_req_addr  <= '0;
         r_req_we    <= 1'b0;
         r_req_wdata <= '0;
         r_hit       <= 1'b0;
         r_cpu_ready <= 1'b0;
         r_cpu_rdata <= '0;
         r_cpu_hit   <= 1'b0;
         r_arr_index <= '0;
         r_arr_we    <= 1'b0;
         r_tag_wr    <= '0;
         r_data_wr   <= '0;
         r_valid_wr  <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         // Completion and array-write strobes are single-cycle pulses
         r_cpu_ready <= 1'b0;
         r_cpu_hit   <= 1'b0;
         r_cpu_rdata <= '0;
         r_arr_we    <= 1'b0;

         case (r_state)
            S_IDLE: begin
               // A request still held during its own ready cycle is the old one
               if (bus.cpu_req && !r_cpu_ready) begin
                  r_req_addr  <= bus.cpu_addr;
                  r_req_we    <= bus.cpu_we;
                  r_req_wdata <= bus.cpu_wdata;
                  r_arr_index <= bus.cpu_addr[IDX_W-1:0];
                  r_state     <= S_LOOKUP;
               end
            end

            S_LOOKUP: begin
               r_hit <= w_hit;
               if (!r_req_we) begin
                  if (w_hit) begin
                     r_cpu_ready <= 1'b1;
                     r_cpu_hit   <= 1'b1;
                     r_cpu_rdata <= bus.data_rd;
                     r_state     <= S_IDLE;
                  end else begin
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= r_req_addr;
                     r_state    <= S_REFILL;
                  end
               end else begin
                  // Store: update the line only if resident, always write through
                  if (w_hit) begin
                     r_arr_we   <= 1'b1;
                     r_tag_wr   <= w_req_tag;
                     r_data_wr  <= r_req_wdata;
                     r_valid_wr <= 1'b1;
                  end
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_req_addr;
                  r_mem_wdata <= r_req_wdata;
                  r_state     <= S_WTHRU;
               end
            end

            S_REFILL: begin
               if (bus.mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_arr_we    <= 1'b1;
                  r_tag_wr    <= w_req_tag;
                  r_data_wr   <= bus.mem_rdata;
                  r_valid_wr  <= 1'b1;
                  r_cpu_ready <= 1'b1;
                  r_cpu_hit   <= 1'b0;
                  r_cpu_rdata <= bus.mem_rdata;
                  r_state     <= S_IDLE;
               end
            end

            S_WTHRU: begin
               if (bus.mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_cpu_ready <= 1'b1;
                  r_cpu_hit   <= r_hit;
                  r_state     <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_ready = r_cpu_ready;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.cpu_hit   = r_cpu_hit;
   assign bus.arr_index = r_arr_index;
   assign bus.arr_we    = r_arr_we;
   assign bus.tag_wr    = r_tag_wr;
   assign bus.data_wr   = r_data_wr;
   assign bus.valid_wr  = r_valid_wr;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

`ifdef CACHE_CTRL_STATS_EN
   logic        w_fin_hit;
   logic        w_fin_miss;
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;

   // Transaction completions, aligned with the edge that raises cpu_ready
   assign w_fin_hit  = ((r_state == S_LOOKUP) & ~r_req_we & w_hit) |
                       ((r_state == S_WTHRU) & bus.mem_ack & r_hit);
   assign w_fin_miss = ((r_state == S_REFILL) & bus.mem_ack) |
                       ((r_state == S_WTHRU) & bus.mem_ack & ~r_hit);

   // Saturating hit/miss counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hit_cnt  <= 16'd0;
         r_miss_cnt <= 16'd0;
      end else begin
         if (w_fin_hit && (r_hit_cnt != 16'hFFFF))
            r_hit_cnt <= r_hit_cnt + 16'd1;
         if (w_fin_miss && (r_miss_cnt != 16'hFFFF))
            r_miss_cnt <= r_miss_cnt + 16'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller.
// The bench owns the tag/data/valid arrays: writes land on the falling edge,
// and reads are combinational from arr_index.
// The reference model keeps which full address is resident in each line.
module tb_cache_controller;
   localparam int unsigned ADDR_W = 29;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned TAG_W  = ADDR_W - IDX_W;
   localparam int unsigned NLINE  = 1 << IDX_W;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   cache_controller_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_if ();

`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   cache_controller #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (u_if)
`ifdef CACHE_CTRL_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical cache arrays
   logic [TAG_W-1:0]  a_tag  [NLINE];
   logic [DATA_W-1:0] a_data [NLINE];
   logic              a_val  [NLINE];

   assign u_if.tag_rd   = a_tag[u_if.arr_index];
   assign u_if.data_rd  = a_data[u_if.arr_index];
   assign u_if.valid_rd = a_val[u_if.arr_index];

   always @(negedge clk) begin
      if (u_if.arr_we) begin
         a_tag[u_if.arr_index]  <= u_if.tag_wr;
         a_data[u_if.arr_index] <= u_if.data_wr;
         a_val[u_if.arr_index]  <= u_if.valid_wr;
      end
   end

   // Reference model: resident address and data per line, plus hit/miss tallies
   logic [ADDR_W-1:0] m_addr [NLINE];
   logic [DATA_W-1:0] m_data [NLINE];
   bit                m_val  [NLINE];
   int                m_hits = 0;
   int                m_miss = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // One CPU transaction, checked against the model
   task automatic txn(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                      input logic [DATA_W-1:0] mrd, input int d,
                      output bit o_hit, output logic [DATA_W-1:0] o_rd);
      int                idx;
      bit                e_hit, e_mem, e_arr;
      logic [DATA_W-1:0] e_data;
      int                e_lat;
      int                cyc, wcnt, arr_cnt, lat;
      bit                done, mseen;
      logic              g_mwe;
      logic [ADDR_W-1:0] g_maddr;
      logic [DATA_W-1:0] g_mwd;
      logic [IDX_W-1:0]  g_idx;
      logic [TAG_W-1:0]  g_tag;
      logic [DATA_W-1:0] g_dwr;
      logic              g_vwr;

      idx    = int'(addr % ADDR_W'(NLINE));
      e_hit  = m_val[idx] && (m_addr[idx] == addr);
      e_mem  = we || !e_hit;
      e_arr  = we ? e_hit : !e_hit;
      e_data = we ? wd : (e_hit ? m_data[idx] : mrd);
      e_lat  = (!we && e_hit) ? 2 : 3 + d;

      cyc = 0; wcnt = 0; arr_cnt = 0; lat = 0; done = 0; mseen = 0;
      g_mwe = 0; g_maddr = '0; g_mwd = '0; g_idx = '0; g_tag = '0; g_dwr = '0; g_vwr = 0;
      o_hit = 0; o_rd = '0;

      u_if.cpu_req   = 1'b1;
      u_if.cpu_we    = we;
      u_if.cpu_addr  = addr;
      u_if.cpu_wdata = wd;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         u_if.mem_ack = 1'b0;
         if (u_if.mem_req && !mseen) begin
            mseen   = 1;
            g_mwe   = u_if.mem_we;
            g_maddr = u_if.mem_addr;
            g_mwd   = u_if.mem_wdata;
         end
         if (u_if.arr_we) begin
            arr_cnt++;
            g_idx = u_if.arr_index;
            g_tag = u_if.tag_wr;
            g_dwr = u_if.data_wr;
            g_vwr = u_if.valid_wr;
         end
         if (u_if.cpu_ready) begin
            done         = 1;
            lat          = cyc;
            o_hit        = u_if.cpu_hit;
            o_rd         = u_if.cpu_rdata;
            u_if.cpu_req = 1'b0;
            chk("mem_req_drop", 32'(u_if.mem_req), 32'd0);
         end else if (u_if.mem_req) begin
            if (wcnt == d) begin
               u_if.mem_ack   = 1'b1;
               u_if.mem_rdata = mrd;
            end
            wcnt++;
         end
      end
      u_if.mem_ack = 1'b0;
      u_if.cpu_req = 1'b0;

      chk("ready_seen", 32'(done), 32'd1);
      if (done) begin
         chk("latency", 32'(lat), 32'(e_lat));
         chk("cpu_hit", 32'(o_hit), 32'(e_hit));
         if (!we) chk("cpu_rdata", 32'(o_rd), 32'(e_data));
      end
      chk("mem_req_seen", 32'(mseen), 32'(e_mem));
      if (mseen && e_mem) begin
         chk("mem_we", 32'(g_mwe), 32'(we));
         chk("mem_addr", 32'(g_maddr), 32'(addr));
         if (we) chk("mem_wdata", 32'(g_mwd), 32'(wd));
      end
      chk("arr_we_count", 32'(arr_cnt), 32'(e_arr));
      if (arr_cnt == 1 && e_arr) begin
         chk("arr_index", 32'(g_idx), 32'(idx));
         chk("tag_wr", 32'(g_tag), 32'(addr >> IDX_W));
         chk("data_wr", 32'(g_dwr), 32'(e_data));
         chk("valid_wr", 32'(g_vwr), 32'd1);
      end

      // The pulses must not repeat in the following cycle
      @(posedge clk); #1;
      chk("ready_pulse", 32'(u_if.cpu_ready), 32'd0);
      chk("arr_we_pulse", 32'(u_if.arr_we), 32'd0);
      chk("mem_req_idle", 32'(u_if.mem_req), 32'd0);

      if (!we && !e_hit) begin
         m_val[idx]  = 1;
         m_addr[idx] = addr;
         m_data[idx] = mrd;
      end
      if (we && e_hit) m_data[idx] = wd;
      if (e_hit) m_hits++;
      else m_miss++;
   endtask

   typedef struct {
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] mrd;
      int                d;
      bit                ehit;
      logic [DATA_W-1:0] erd;
   } vec_t;

   vec_t              vt [12];
   logic [TAG_W-1:0]  tpool [4];
   bit                r_hit;
   logic [DATA_W-1:0] r_rd;
   logic [ADDR_W-1:0] raddr;
   logic [TAG_W-1:0]  rtag;
   logic [IDX_W-1:0]  ridx;

   initial begin
      vt[0]  = '{0, 29'h00000A5, 8'h00, 8'h3C, 0, 0, 8'h3C};
      vt[1]  = '{0, 29'h00000A5, 8'h00, 8'hEE, 0, 1, 8'h3C};
      vt[2]  = '{0, 29'h00001AD, 8'h00, 8'h55, 2, 0, 8'h55};
      vt[3]  = '{0, 29'h00000A5, 8'h00, 8'h3C, 1, 0, 8'h3C};
      vt[4]  = '{1, 29'h00000A5, 8'h7E, 8'h00, 0, 1, 8'h00};
      vt[5]  = '{0, 29'h00000A5, 8'h00, 8'hEE, 0, 1, 8'h7E};
      vt[6]  = '{1, 29'h00001AD, 8'h11, 8'h00, 1, 0, 8'h00};
      vt[7]  = '{0, 29'h00001AD, 8'h00, 8'h99, 0, 0, 8'h99};
      vt[8]  = '{0, 29'h00000A5, 8'h00, 8'h42, 3, 0, 8'h42};
      vt[9]  = '{0, 29'h1FFFFFFF, 8'h00, 8'hF0, 0, 0, 8'hF0};
      vt[10] = '{0, 29'h1FFFFFFF, 8'h00, 8'h00, 0, 1, 8'hF0};
      vt[11] = '{0, 29'h0FFFFFFF, 8'h00, 8'h0F, 1, 0, 8'h0F};
      tpool[0] = 26'h0000000;
      tpool[1] = 26'h0000001;
      tpool[2] = 26'h3FFFFFF;
      tpool[3] = 26'h2AAAAAA;

      for (int i = 0; i < int'(NLINE); i++) begin
         a_tag[i] = '0; a_data[i] = '0; a_val[i] = 1'b0;
         m_addr[i] = '0; m_data[i] = '0; m_val[i] = 0;
      end

      reset          = 1'b0;
      u_if.cpu_req   = 1'b0;
      u_if.cpu_we    = 1'b0;
      u_if.cpu_addr  = '0;
      u_if.cpu_wdata = '0;
      u_if.mem_ack   = 1'b0;
      u_if.mem_rdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_ready", 32'(u_if.cpu_ready), 32'd0);
      chk("rst_cpu_hit", 32'(u_if.cpu_hit), 32'd0);
      chk("rst_cpu_rdata", 32'(u_if.cpu_rdata), 32'd0);
      chk("rst_arr_we", 32'(u_if.arr_we), 32'd0);
      chk("rst_arr_index", 32'(u_if.arr_index), 32'd0);
      chk("rst_mem_req", 32'(u_if.mem_req), 32'd0);
      chk("rst_mem_addr", 32'(u_if.mem_addr), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         txn(vt[i].we, vt[i].addr, vt[i].wd, vt[i].mrd, vt[i].d, r_hit, r_rd);
         chk($sformatf("vec%0d_hit", i), 32'(r_hit), 32'(vt[i].ehit));
         if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), 32'(r_rd), 32'(vt[i].erd));
      end

      // Stray ack while idle must be ignored
      u_if.mem_ack = 1'b1;
      @(posedge clk); #1;
      u_if.mem_ack = 1'b0;
      chk("stray_ack_ready", 32'(u_if.cpu_ready), 32'd0);
      chk("stray_ack_arr_we", 32'(u_if.arr_we), 32'd0);

      // Reset asserted in REFILL with the ack still pending
      u_if.cpu_req  = 1'b1;
      u_if.cpu_we   = 1'b0;
      u_if.cpu_addr = 29'h00000F3;
      begin : wait_refill
         bit seen;
         seen = 0;
         for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (u_if.mem_req) seen = 1;
         end
         chk("abort_mem_req_seen", 32'(seen), 32'd1);
      end
      u_if.cpu_req = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("abort_mem_req", 32'(u_if.mem_req), 32'd0);
      chk("abort_mem_addr", 32'(u_if.mem_addr), 32'd0);
      chk("abort_cpu_ready", 32'(u_if.cpu_ready), 32'd0);
      chk("abort_arr_we", 32'(u_if.arr_we), 32'd0);
      chk("abort_arr_index", 32'(u_if.arr_index), 32'd0);
      m_hits = 0;
      m_miss = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      u_if.mem_ack   = 1'b1;
      u_if.mem_rdata = 8'hA1;
      @(posedge clk); #1;
      u_if.mem_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("late_ack_ready", 32'(u_if.cpu_ready), 32'd0);
         chk("late_ack_arr_we", 32'(u_if.arr_we), 32'd0);
         @(posedge clk); #1;
      end
      txn(0, 29'h00000F3, 8'h00, 8'h5A, 1, r_hit, r_rd);
      chk("after_abort_miss", 32'(r_hit), 32'd0);
      chk("after_abort_rdata", 32'(r_rd), 32'h5A);

      // Randomised traffic over a small tag pool so lines get reused
      for (int i = 0; i < 300; i++) begin
         rtag  = tpool[$urandom_range(0, 3)];
         ridx  = IDX_W'($urandom_range(0, int'(NLINE) - 1));
         raddr = {rtag, ridx};
         txn($urandom_range(0, 2) == 0, raddr, DATA_W'($urandom), DATA_W'($urandom),
             $urandom_range(0, 3), r_hit, r_rd);
      end

`ifdef CACHE_CTRL_STATS_EN
      chk("hit_cnt", 32'(hit_cnt), 32'((m_hits > 65535) ? 65535 : m_hits));
      chk("miss_cnt", 32'(miss_cnt), 32'((m_miss > 65535) ? 65535 : m_miss));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
